shift_sequencer: RTL and testbench

//  Initiator side of the combinational rotate unit's bus-strobe interface.
//  - Accepts a multi-step rotate request: operand, direction, step count.
//  - Drives one strobe per cycle (fbus, flbus or frbus) on the unit's operand

---
 rtl/shift_sequencer.sv | 128 ++++++++++++
 tb/tb_shift_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Drives a combinational rotate unit through its bus-strobe interface to
// perform a multi-step rotate. One strobe (fbus, flbus or frbus) is driven per
// cycle; each cycle's result `w` becomes the next operand on `a`. The final
// value and last carry are returned with a one-cycle done pulse.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous reset, active low
//   start  in   1      request strobe, sampled only when idle
//   dir    in   1      0 = rotate left (flbus), 1 = rotate right (frbus)
//   cnt    in   CNT_W  rotate steps; 0 = single pass-through (fbus)
//   din    in   WIDTH  initial operand
//   a      out  WIDTH  operand to the rotate unit
//   fbus   out  1      pass-through strobe
//   flbus  out  1      rotate-left strobe
//   frbus  out  1      rotate-right strobe
//   w      in   WIDTH  result from the rotate unit
//   cf     in   1      carry from the rotate unit
//   busy   out  1      request in progress (pass or step)
//   done   out  1      one-cycle pulse, dout/cout valid
//   dout   out  WIDTH  final result, held until overwritten
//   cout   out  1      carry of the last step, 0 for a pass-through
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a,
  output logic             fbus,
  output logic             flbus,
  output logic             frbus,
  input  logic [WIDTH-1:0] w,
  input  logic             cf,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

  typedef enum logic [1:0] {StIdle, StPass, StStep, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               cout_q, cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      dir_q   <= 1'b0;
      step_q  <= '0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
    end
  end

  // `w` and `cf` are only consumed in PASS/STEP, where a strobe is driven.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    step_d  = step_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d = din;
          dir_d  = dir;
          if (cnt == '0) begin
            state_d = StPass;
          end else begin
            step_d  = cnt;
            state_d = StStep;
          end
        end
      end
      StPass: begin
        dout_d  = w;
        cout_d  = 1'b0;
        state_d = StDone;
      end
      StStep: begin
        work_d = w;
        cout_d = cf;
        step_d = step_q - CNT_W'(1);
        if (step_q == CNT_W'(1)) begin
          dout_d  = w;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs: strobes depend only on registered state, so they are
  // mutually exclusive by construction.
  assign a     = work_q;
  assign fbus  = (state_q == StPass);
  assign flbus = (state_q == StStep) && !dir_q;
  assign frbus = (state_q == StStep) && dir_q;
  assign busy  = (state_q == StPass) || (state_q == StStep);
  assign done  = (state_q == StDone);
  assign dout  = dout_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with a behavioural rotate unit.
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dir;
  logic [2:0] cnt;
  logic [7:0] din;
  logic [7:0] a;
  logic       fbus, flbus, frbus;
  wire  [7:0] w;
  logic       cf;
  logic       busy, done;
  logic [7:0] dout;
  logic       cout;

  logic [7:0] rot;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         onehot_viol = 0;

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dir   (dir),
    .cnt   (cnt),
    .din   (din),
    .a     (a),
    .fbus  (fbus),
    .flbus (flbus),
    .frbus (frbus),
    .w     (w),
    .cf    (cf),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate unit: carry is the bit rotated around.
  always_comb begin
    rot = '0;
    cf  = 1'b0;
    if (fbus) begin
      rot = a;
    end else if (flbus) begin
      rot = {a[6:0], a[7]};
      cf  = a[7];
    end else if (frbus) begin
      rot = {a[0], a[7:1]};
      cf  = a[0];
    end
  end
  assign w = (fbus || flbus || frbus) ? rot : 'z;

  always @(negedge clk) begin
    if (rst_n && !$onehot0({fbus, flbus, frbus})) onehot_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check every cycle through done and the idle cycle after.
  // With disturb set, inputs change after acceptance and start is pulsed
  // during the first step cycle and during the done cycle.
  task automatic run_req(input string tag, input logic [7:0] d, input logic r,
                         input logic [2:0] c, input logic [7:0] last_a,
                         input logic [7:0] exp_dout, input logic exp_cout,
                         input bit disturb);
    int   n;
    logic [2:0] exp_strb;
    n = (c == 3'd0) ? 1 : int'(c);
    exp_strb = (c == 3'd0) ? 3'b100 : (r ? 3'b001 : 3'b010);
    @(negedge clk);
    start = 1'b1; din = d; dir = r; cnt = c;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      din = ~d; dir = ~r; cnt = c ^ 3'b101;
    end
    for (int i = 1; i <= n; i++) begin
      if (i > 1) @(negedge clk);
      if (disturb) start = (i == 1);
      check_eq({tag, "_strobe"}, {29'd0, fbus, flbus, frbus}, {29'd0, exp_strb});
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check_eq({tag, "_nodone"}, {31'd0, done}, 32'd0);
      if (i == 1) check_eq({tag, "_a_first"}, {24'd0, a}, {24'd0, d});
      if (i == n) check_eq({tag, "_a_last"}, {24'd0, a}, {24'd0, last_a});
    end
    @(negedge clk);
    start = disturb;
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done_strobe"}, {29'd0, fbus, flbus, frbus}, 32'd0);
    check_eq({tag, "_dout"}, {24'd0, dout}, {24'd0, exp_dout});
    check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_after_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_after_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_after_dout"}, {24'd0, dout}, {24'd0, exp_dout});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; cnt = '0; din = '0;
    #12;
    check_eq("rst_a", {24'd0, a}, 32'd0);
    check_eq("rst_strobe", {29'd0, fbus, flbus, frbus}, 32'd0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_dout", {24'd0, dout}, 32'd0);
    check_eq("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("t1_rol1",  8'h81, 1'b0, 3'd1, 8'h81, 8'h03, 1'b1, 1'b0);
    run_req("t2_ror3",  8'h01, 1'b1, 3'd3, 8'h40, 8'h20, 1'b0, 1'b0);
    run_req("t3_pass",  8'h5A, 1'b0, 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b0);
    run_req("t4_rol7",  8'h96, 1'b0, 3'd7, 8'hA5, 8'h4B, 1'b1, 1'b0);
    run_req("t5_ignore", 8'h01, 1'b1, 3'd3, 8'h40, 8'h20, 1'b0, 1'b1);

    // Reset in the middle of a 5-step left rotate of 0xF0.
    @(negedge clk);
    start = 1'b1; din = 8'hF0; dir = 1'b0; cnt = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("t6_pre_cout", {31'd0, cout}, 32'd1);
    check_eq("t6_pre_a", {24'd0, a}, 32'hE1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_strobe", {29'd0, fbus, flbus, frbus}, 32'd0);
    check_eq("t6_rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("t6_rst_dout", {24'd0, dout}, 32'd0);
    check_eq("t6_rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("t6_after", 8'hF0, 1'b0, 3'd5, 8'h0F, 8'h1E, 1'b0, 1'b0);

    check_eq("onehot", onehot_viol, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
